csr_trap_sequencer: RTL and testbench

- Multi-cycle controller that sequences every CSR access and M-mode trap entry/exit through the register heap's CSR ports.
- Sits between the decode/execute stage and the register heap. It accepts one request at a time (CSRRW/CSRRS/CSRRC, ECALL, MRET).
- It performs read-modify-write on mstatus/mtvec/mepc/mcause and returns the old CSR value or a PC redirect.
- The heap writes CSRs on negedge and reads them combinationally; this block runs entirely on posedge.

---
 rtl/csr_trap_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_csr_trap_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_sequencer.sv
// Sequences CSR read-modify-write ops and M-mode trap entry/exit through the heap's CSR ports.
// The heap reads combinationally and writes on negedge, so one state per heap access is enough.
module csr_trap_sequencer #(
    parameter logic [31:0] ECALL_CAUSE = 32'd11,
    parameter logic [1:0]  MPP_M       = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_csr,
    input  logic [31:0] req_wdata,
    input  logic        req_nowr,
    input  logic [31:0] req_pc,
    output logic [11:0] csr_s,
    input  logic [31:0] csr_src,
    output logic [11:0] csr_d1,
    output logic        csr_wen1,
    output logic [31:0] csr_wdata1,
    output logic [11:0] csr_d2,
    output logic        csr_wen2,
    output logic [31:0] csr_wdata2,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        err,
    output logic        busy
);

    localparam logic [2:0]  OP_RW    = 3'd0;
    localparam logic [2:0]  OP_RS    = 3'd1;
    localparam logic [2:0]  OP_RC    = 3'd2;
    localparam logic [2:0]  OP_ECALL = 3'd4;
    localparam logic [2:0]  OP_MRET  = 3'd5;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [31:0] MPP_FIELD = {19'b0, MPP_M, 11'b0};

    typedef enum logic [3:0] {
        S_IDLE, S_CRD, S_CWR, S_DONE,
        S_EWR, S_ERDS, S_EWRS, S_ERDT,
        S_MRDS, S_MWRS, S_MRDE
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [11:0] csr_q, csr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        nowr_q, nowr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] old_q, old_d;

    logic is_csr_op;
    logic csr_ok;

    assign is_csr_op = (op_q == OP_RW) || (op_q == OP_RS) || (op_q == OP_RC);
    assign csr_ok    = (csr_q == A_MSTATUS) || (csr_q == A_MTVEC) ||
                       (csr_q == A_MEPC)    || (csr_q == A_MCAUSE);

    // NOTE: only non-blocking assignments here; state updates must all see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            csr_q   <= '0;
            wdata_q <= '0;
            nowr_q  <= 1'b0;
            pc_q    <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            csr_q   <= csr_d;
            wdata_q <= wdata_d;
            nowr_q  <= nowr_d;
            pc_q    <= pc_d;
            old_q   <= old_d;
        end
    end

    // NOTE: every signal written below gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        csr_d          = csr_q;
        wdata_d        = wdata_q;
        nowr_d         = nowr_q;
        pc_d           = pc_q;
        old_d          = old_q;
        req_ready      = 1'b0;
        csr_s          = '0;
        csr_d1         = '0;
        csr_wen1       = 1'b0;
        csr_wdata1     = '0;
        csr_d2         = '0;
        csr_wen2       = 1'b0;
        csr_wdata2     = '0;
        done           = 1'b0;
        rd_data        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        err            = 1'b0;
        busy           = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    csr_d   = req_csr;
                    wdata_d = req_wdata;
                    nowr_d  = req_nowr;
                    pc_d    = req_pc;
                    old_d   = '0;
                    case (req_op)
                        OP_RW, OP_RS, OP_RC: state_d = S_CRD;
                        OP_ECALL:            state_d = S_EWR;
                        OP_MRET:             state_d = S_MRDS;
                        default:             state_d = S_DONE;
                    endcase
                end
            end
            S_CRD: begin
                csr_s   = csr_q;
                old_d   = csr_src;
                state_d = S_CWR;
            end
            S_CWR: begin
                csr_d1 = csr_q;
                case (op_q)
                    OP_RS:   csr_wdata1 = old_q | wdata_q;
                    OP_RC:   csr_wdata1 = old_q & ~wdata_q;
                    default: csr_wdata1 = wdata_q;
                endcase
                csr_wen1 = csr_ok && !((op_q != OP_RW) && nowr_q);
                state_d  = S_DONE;
            end
            S_EWR: begin
                csr_d1     = A_MEPC;
                csr_wdata1 = pc_q;
                csr_wen1   = 1'b1;
                csr_d2     = A_MCAUSE;
                csr_wdata2 = ECALL_CAUSE;
                csr_wen2   = 1'b1;
                state_d    = S_ERDS;
            end
            S_ERDS: begin
                csr_s   = A_MSTATUS;
                old_d   = csr_src;
                state_d = S_EWRS;
            end
            S_EWRS: begin
                // MPIE <= MIE, MIE <= 0, MPP <= M
                csr_d1     = A_MSTATUS;
                csr_wdata1 = (old_q & ~32'h0000_1888) | {24'b0, old_q[3], 7'b0} | MPP_FIELD;
                csr_wen1   = 1'b1;
                state_d    = S_ERDT;
            end
            S_ERDT: begin
                csr_s   = A_MTVEC;
                old_d   = csr_src;
                state_d = S_DONE;
            end
            S_MRDS: begin
                csr_s   = A_MSTATUS;
                old_d   = csr_src;
                state_d = S_MWRS;
            end
            S_MWRS: begin
                // MIE <= MPIE, MPIE <= 1, MPP <= M
                csr_d1     = A_MSTATUS;
                csr_wdata1 = (old_q & ~32'h0000_1808) | {28'b0, old_q[7], 3'b0} |
                             32'h0000_0080 | MPP_FIELD;
                csr_wen1   = 1'b1;
                state_d    = S_MRDE;
            end
            S_MRDE: begin
                csr_s   = A_MEPC;
                old_d   = csr_src;
                state_d = S_DONE;
            end
            S_DONE: begin
                done           = 1'b1;
                err            = is_csr_op ? !csr_ok : !((op_q == OP_ECALL) || (op_q == OP_MRET));
                rd_data        = (is_csr_op && csr_ok) ? old_q : 32'h0;
                redirect_valid = (op_q == OP_ECALL) || (op_q == OP_MRET);
                redirect_pc    = (op_q == OP_ECALL) ? (old_q & ~32'h3) :
                                 (op_q == OP_MRET)  ? old_q : 32'h0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are gated by reset so a sequence cut short never lands another heap write.
        if (!rst) begin
            req_ready      = 1'b1;
            csr_s          = '0;
            csr_d1         = '0;
            csr_wen1       = 1'b0;
            csr_wdata1     = '0;
            csr_d2         = '0;
            csr_wen2       = 1'b0;
            csr_wdata2     = '0;
            done           = 1'b0;
            rd_data        = '0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            err            = 1'b0;
            busy           = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer with a behavioural CSR heap (negedge write, combinational read).
module tb_csr_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_csr;
    logic [31:0] req_wdata;
    logic        req_nowr;
    logic [31:0] req_pc;
    logic [11:0] csr_s;
    logic [31:0] csr_src;
    logic [11:0] csr_d1;
    logic        csr_wen1;
    logic [31:0] csr_wdata1;
    logic [11:0] csr_d2;
    logic        csr_wen2;
    logic [31:0] csr_wdata2;
    logic        done;
    logic [31:0] rd_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] h_mstatus, h_mtvec, h_mepc, h_mcause;
    int          wen1_cnt = 0;
    int          wen2_cnt = 0;

    always #5 clk = ~clk;

    csr_trap_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr(req_csr), .req_wdata(req_wdata), .req_nowr(req_nowr), .req_pc(req_pc),
        .csr_s(csr_s), .csr_src(csr_src),
        .csr_d1(csr_d1), .csr_wen1(csr_wen1), .csr_wdata1(csr_wdata1),
        .csr_d2(csr_d2), .csr_wen2(csr_wen2), .csr_wdata2(csr_wdata2),
        .done(done), .rd_data(rd_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .err(err), .busy(busy)
    );

    always_comb begin
        case (csr_s)
            12'h300: csr_src = h_mstatus;
            12'h305: csr_src = h_mtvec;
            12'h341: csr_src = h_mepc;
            12'h342: csr_src = h_mcause;
            default: csr_src = 32'h0;
        endcase
    end

    task automatic heap_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: h_mstatus = d;
            12'h305: h_mtvec   = d;
            12'h341: h_mepc    = d;
            12'h342: h_mcause  = d;
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (csr_wen1) begin
            heap_write(csr_d1, csr_wdata1);
            wen1_cnt++;
        end
        if (csr_wen2) begin
            heap_write(csr_d2, csr_wdata2);
            wen2_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [11:0] csr;
        logic [31:0] wdata;
        logic        nowr;
        logic [31:0] pc;
        int          lat;
        logic [31:0] rd;
        logic        err;
        logic        rv;
        logic [31:0] rpc;
        int          w1;
        int          w2;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          lat;
        int          w1_start, w2_start;
        logic [31:0] got_rd, got_rpc;
        logic        got_err, got_rv, seen_done;

        vecs[0]  = '{3'd1, 12'h300, 32'h0,        1'b1, 32'h0,        3, 32'h0000_1800, 1'b0, 1'b0, 32'h0,        0, 0, 32'h1800, 32'h0};
        vecs[1]  = '{3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0,       3, 32'h0,         1'b0, 1'b0, 32'h0,        1, 0, 32'h1800, 32'h8000_0100};
        vecs[2]  = '{3'd2, 12'h305, 32'h3,        1'b0, 32'h0,        3, 32'h8000_0100, 1'b0, 1'b0, 32'h0,        1, 0, 32'h1800, 32'h8000_0100};
        vecs[3]  = '{3'd0, 12'h305, 32'h8000_0101, 1'b0, 32'h0,       3, 32'h8000_0100, 1'b0, 1'b0, 32'h0,        1, 0, 32'h1800, 32'h8000_0101};
        vecs[4]  = '{3'd1, 12'h300, 32'h8,        1'b0, 32'h0,        3, 32'h0000_1800, 1'b0, 1'b0, 32'h0,        1, 0, 32'h1808, 32'h8000_0101};
        vecs[5]  = '{3'd4, 12'h0,   32'h0,        1'b0, 32'h8000_0040, 5, 32'h0,        1'b0, 1'b1, 32'h8000_0100, 2, 1, 32'h1880, 32'h8000_0101};
        vecs[6]  = '{3'd5, 12'h0,   32'h0,        1'b0, 32'h0,        4, 32'h0,         1'b0, 1'b1, 32'h8000_0040, 1, 0, 32'h1888, 32'h8000_0101};
        vecs[7]  = '{3'd1, 12'h342, 32'h0,        1'b1, 32'h0,        3, 32'd11,        1'b0, 1'b0, 32'h0,        0, 0, 32'h1888, 32'h8000_0101};
        vecs[8]  = '{3'd0, 12'h7C0, 32'h1234,     1'b0, 32'h0,        3, 32'h0,         1'b1, 1'b0, 32'h0,        0, 0, 32'h1888, 32'h8000_0101};
        vecs[9]  = '{3'd3, 12'h300, 32'hFFFF,     1'b0, 32'h0,        1, 32'h0,         1'b1, 1'b0, 32'h0,        0, 0, 32'h1888, 32'h8000_0101};
        vecs[10] = '{3'd1, 12'h341, 32'h0,        1'b1, 32'h0,        3, 32'h8000_0040, 1'b0, 1'b0, 32'h0,        0, 0, 32'h1888, 32'h8000_0101};

        h_mstatus = 32'h1800;
        h_mtvec   = 32'h0;
        h_mepc    = 32'h0;
        h_mcause  = 32'h0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_csr   = '0;
        req_wdata = '0;
        req_nowr  = 1'b0;
        req_pc    = '0;

        tick();
        tick();
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset wen", 32'({csr_wen1, csr_wen2}), 32'd0);
        check("reset csr_s", 32'(csr_s), 32'd0);
        check("reset rd/redir/err", rd_data | redirect_pc | 32'({redirect_valid, err}), 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            w1_start  = wen1_cnt;
            w2_start  = wen2_cnt;
            req_op    = vecs[i].op;
            req_csr   = vecs[i].csr;
            req_wdata = vecs[i].wdata;
            req_nowr  = vecs[i].nowr;
            req_pc    = vecs[i].pc;
            req_valid = 1'b1;
            #1;
            check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
            lat     = 0;
            got_rd  = '0;
            got_rpc = '0;
            got_err = 1'b0;
            got_rv  = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (k == 1) begin
                    // Garbage offered while busy must be ignored.
                    req_op    = 3'd7;
                    req_csr   = 12'h300;
                    req_wdata = 32'hFFFF_FFFF;
                    req_nowr  = 1'b0;
                end
                #1;
                if (done) begin
                    lat     = k;
                    got_rd  = rd_data;
                    got_err = err;
                    got_rv  = redirect_valid;
                    got_rpc = redirect_pc;
                    req_valid = 1'b0;
                    break;
                end
            end
            req_valid = 1'b0;
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d rd_data", i), got_rd, vecs[i].rd);
            check($sformatf("v%0d err", i), 32'(got_err), 32'(vecs[i].err));
            check($sformatf("v%0d redirect_valid", i), 32'(got_rv), 32'(vecs[i].rv));
            check($sformatf("v%0d redirect_pc", i), got_rpc, vecs[i].rpc);
            tick();
            #1;
            check($sformatf("v%0d done pulse width", i), 32'({done, req_ready, busy}), 32'b010);
            check($sformatf("v%0d wen1 count", i), 32'(wen1_cnt - w1_start), 32'(vecs[i].w1));
            check($sformatf("v%0d wen2 count", i), 32'(wen2_cnt - w2_start), 32'(vecs[i].w2));
            check($sformatf("v%0d mstatus", i), h_mstatus, vecs[i].mstatus);
            check($sformatf("v%0d mtvec", i), h_mtvec, vecs[i].mtvec);
        end
        check("mepc after ecall", h_mepc, 32'h8000_0040);
        check("mcause after ecall", h_mcause, 32'd11);

        // Reset landing in the EWRS cycle of an ECALL.
        h_mstatus = 32'h1808;
        h_mepc    = 32'h0;
        h_mcause  = 32'h0;
        req_op    = 3'd4;
        req_pc    = 32'h8000_0200;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid-reset wen1 gated", 32'(csr_wen1), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("mid-reset idle", 32'({busy, req_ready}), 32'b01);
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            #1;
            if (done) seen_done = 1'b1;
        end
        check("mid-reset no done", 32'(seen_done), 32'd0);
        check("mid-reset mepc", h_mepc, 32'h8000_0200);
        check("mid-reset mcause", h_mcause, 32'd11);
        check("mid-reset mstatus", h_mstatus, 32'h1808);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
